dlmac_seq_ctrl: RTL and testbench

- Command-driven sequencer that runs one DLfloat16 dot product of length N on the shared DLfloat MAC datapath.
- Accepts a length command, then streams N operand pairs (valid/ready) into the MAC.
- Drives MAC clear/enable, waits out the MAC pipeline latency, and returns the accumulated result on a valid/ready result port.
- Sits between the byte-level I/O wrappers and the MAC core.

---
 rtl/dlmac_pkg.sv | 22 ++
 rtl/dlmac_op_reg.sv | 63 ++++++
 rtl/dlmac_seq_ctrl.sv | 132 +++++++++++++
 tb/tb_dlmac_seq_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dlmac_pkg.sv
// DLfloat16 MAC sequencer: shared constants, FSM state encoding and
// a NaN-pattern helper used by the operand register and the top.
package dlmac_pkg;

    localparam int          DL_W    = 16;
    localparam logic [15:0] DL_NAN  = 16'hFFFF;
    localparam logic [15:0] DL_ZERO = 16'h0000;
    localparam logic [15:0] DL_ONE  = 16'h3E00;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_FEED  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    function automatic logic is_nan(input logic [DL_W-1:0] v);
        return v == DL_NAN;
    endfunction

endpackage

// File: rtl/dlmac_op_reg.sv
// Operand pipeline register feeding the MAC: captures a/b on each
// accepted operand pair and pulses mac_en the following cycle.
// Ports: clk, rst (async high), clr (drop nan flag), hs (handshake),
//        a/b in, mac_a/mac_b/mac_en out, nan (sticky flag out).
// Optional: DLMAC_NAN_ABORT_EN gates mac_en after a NaN operand.
module dlmac_op_reg
    import dlmac_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            hs,
    input  logic [DL_W-1:0] a,
    input  logic [DL_W-1:0] b,
    output logic [DL_W-1:0] mac_a,
    output logic [DL_W-1:0] mac_b,
    output logic            mac_en,
    output logic            nan
);

    logic fire;

`ifdef DLMAC_NAN_ABORT_EN
    logic nan_q;
    logic hit;

    // The NaN pair itself is suppressed too, not just later ones.
    assign hit  = hs && (is_nan(a) || is_nan(b));
    assign fire = hs && !nan_q && !hit;
    assign nan  = nan_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            nan_q <= 1'b0;
        end else if (clr) begin
            nan_q <= 1'b0;
        end else if (hit) begin
            nan_q <= 1'b1;
        end
    end
`else
    logic unused_clr;

    assign unused_clr = clr;
    assign fire       = hs;
    assign nan        = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mac_a  <= DL_ZERO;
            mac_b  <= DL_ZERO;
            mac_en <= 1'b0;
        end else begin
            mac_en <= fire;
            if (hs) begin
                mac_a <= a;
                mac_b <= b;
            end
        end
    end

endmodule

// File: rtl/dlmac_seq_ctrl.sv
// Sequencer for one DLfloat16 dot product of length N on the MAC.
// Ports: cmd_* (length command), op_* (operand stream), mac_* (MAC
//        drive/acc), res_* (result), busy; clk, rst (async high).
// Optional: DLMAC_NAN_ABORT_EN forces a NaN result after NaN input.
module dlmac_seq_ctrl
    import dlmac_pkg::*;
#(
    parameter int LEN_W   = 8,
    parameter int MAC_LAT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [15:0]      op_a,
    input  logic [15:0]      op_b,
    output logic             mac_clr,
    output logic             mac_en,
    output logic [15:0]      mac_a,
    output logic [15:0]      mac_b,
    input  logic [15:0]      mac_acc,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [15:0]      res_data,
    output logic             busy
);

    localparam int DRN_W = $clog2(MAC_LAT + 2);

    state_t           state_q;
    state_t           state_d;
    logic [LEN_W-1:0] rem_q;
    logic [DRN_W-1:0] drn_q;
    logic             cmd_hs;
    logic             op_hs;
    logic             last_op;
    logic             drn_end;
    logic             nan;

    assign cmd_ready = (state_q == ST_IDLE);
    assign op_ready  = (state_q == ST_FEED);
    assign res_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);

    assign cmd_hs  = cmd_valid && cmd_ready;
    assign op_hs   = op_valid && op_ready;
    assign last_op = op_hs && (rem_q == LEN_W'(1));
    assign drn_end = (state_q == ST_DRAIN) && (drn_q == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (cmd_hs) begin
                    state_d = (cmd_len == '0) ? ST_DONE : ST_CLEAR;
                end
            end
            ST_CLEAR: state_d = ST_FEED;
            ST_FEED: begin
                if (last_op) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (drn_end) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (res_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // mac_clr is registered so it lines up with the CLEAR cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_q    <= '0;
            drn_q    <= '0;
            mac_clr  <= 1'b0;
            res_data <= DL_ZERO;
        end else begin
            mac_clr <= (state_d == ST_CLEAR);

            if (cmd_hs) begin
                rem_q <= cmd_len;
            end else if (op_hs) begin
                rem_q <= rem_q - LEN_W'(1);
            end

            if (last_op) begin
                drn_q <= DRN_W'(MAC_LAT);
            end else if (state_q == ST_DRAIN && drn_q != '0) begin
                drn_q <= drn_q - DRN_W'(1);
            end

            if (cmd_hs && cmd_len == '0) begin
                res_data <= DL_ZERO;
            end else if (drn_end) begin
                res_data <= nan ? DL_NAN : mac_acc;
            end
        end
    end

    dlmac_op_reg u_op_reg (
        .clk    (clk),
        .rst    (rst),
        .clr    (state_d == ST_CLEAR),
        .hs     (op_hs),
        .a      (op_a),
        .b      (op_b),
        .mac_a  (mac_a),
        .mac_b  (mac_b),
        .mac_en (mac_en),
        .nan    (nan)
    );

endmodule

// File: tb/tb_dlmac_seq_ctrl.sv
// Self-checking bench for dlmac_seq_ctrl with a behavioural integer
// MAC (latency 2) and a transaction-level expected-result model.
module tb_dlmac_seq_ctrl;

    localparam int LEN_W   = 8;
    localparam int MAC_LAT = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [LEN_W-1:0] cmd_len = '0;
    logic             op_valid = 1'b0;
    logic             op_ready;
    logic [15:0]      op_a = '0;
    logic [15:0]      op_b = '0;
    logic             mac_clr;
    logic             mac_en;
    logic [15:0]      mac_a;
    logic [15:0]      mac_b;
    logic [15:0]      mac_acc;
    logic             res_valid;
    logic             res_ready = 1'b0;
    logic [15:0]      res_data;
    logic             busy;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int en_cnt = 0;
    int clr_cnt = 0;

    logic [15:0] opa [16];
    logic [15:0] opb [16];

    dlmac_seq_ctrl #(.LEN_W(LEN_W), .MAC_LAT(MAC_LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_len   (cmd_len),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .mac_clr   (mac_clr),
        .mac_en    (mac_en),
        .mac_a     (mac_a),
        .mac_b     (mac_b),
        .mac_acc   (mac_acc),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    // Small non-negative integers <-> DLfloat16 (1/6/9, bias 31).
    function automatic logic [15:0] int2dl(input int n);
        int e;
        int m;
        if (n <= 0) return 16'h0000;
        e = 0;
        for (int i = 0; i < 16; i++) if (((n >> i) & 1) != 0) e = i;
        m = (e <= 9) ? ((n << (9 - e)) & 511) : ((n >> (e - 9)) & 511);
        return {1'b0, 6'(e + 31), 9'(m)};
    endfunction

    function automatic int dl2int(input logic [15:0] x);
        int e;
        if (x == 16'h0000) return 0;
        e = int'(x[14:9]) - 31;
        if (e < 0) return 0;
        return ((512 + int'(x[8:0])) << e) >> 9;
    endfunction

    // Behavioural MAC: multiply register then accumulator register.
    int acc = 0;
    int prod = 0;
    bit pv = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            acc  <= 0;
            prod <= 0;
            pv   <= 1'b0;
        end else if (mac_clr) begin
            acc <= 0;
            pv  <= 1'b0;
        end else begin
            pv   <= mac_en;
            prod <= dl2int(mac_a) * dl2int(mac_b);
            if (pv) acc <= acc + prod;
        end
    end

    assign mac_acc = int2dl(acc);

    always @(negedge clk) begin
        if (mac_en) en_cnt++;
        if (mac_clr) clr_cnt++;
        if (!rst) begin
            chk("clr_en_excl", {31'b0, mac_clr & mac_en}, 0);
            chk("rdy_excl", {31'b0, cmd_ready & op_ready}, 0);
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        cmd_valid = 1'b0;
        op_valid = 1'b0;
        res_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // mode 0: back-to-back, 1: alternating, 2: random gaps
    task automatic run_cmd(input int len, input int mode, input int gap,
                           input int hold, output logic [15:0] got);
        int t0;
        int h;
        int tv;
        int i;
        int k;
        int sum;
        int exp_en;
        int exp_lat;
        bit hs;
        bit nan_seen;
        logic [15:0] exp_res;

        got = 16'h0000;
        k = 0;
        while (!cmd_ready && k < 20) begin
            @(posedge clk);
            #1 k++;
        end
        chk("cmd_ready", {31'b0, cmd_ready}, 1);
        if (!cmd_ready) begin
            do_reset();
            return;
        end

        sum = 0;
        exp_en = len;
        nan_seen = 1'b0;
        for (int j = 0; j < len; j++) begin
`ifdef DLMAC_NAN_ABORT_EN
            if (opa[j] == 16'hFFFF || opb[j] == 16'hFFFF) begin
                if (!nan_seen) exp_en = j;
                nan_seen = 1'b1;
            end
`endif
            if (!nan_seen) sum += dl2int(opa[j]) * dl2int(opb[j]);
        end
        exp_res = nan_seen ? 16'hFFFF : int2dl(sum);

        t0 = cyc;
        en_cnt = 0;
        clr_cnt = 0;
        cmd_valid = 1'b1;
        cmd_len = LEN_W'(len);
        @(posedge clk);
        #1 cmd_valid = 1'b0;

        h = t0;
        if (len > 0) begin
            chk("clr_cycle1", {31'b0, mac_clr}, 1);
            i = 0;
            k = 0;
            while (i < len && k < 200) begin
                case (mode)
                    0: op_valid = 1'b1;
                    1: op_valid = (k % 2) == 1;
                    default: op_valid = ($urandom_range(99) >= gap);
                endcase
                op_a = opa[i];
                op_b = opb[i];
                hs = op_valid && op_ready;
                if (hs) h = cyc;
                @(posedge clk);
                #1 if (hs) i++;
                k++;
            end
            op_valid = 1'b0;
            chk("feed_done", i, len);
            if (i != len) begin
                do_reset();
                return;
            end
            chk("op_ready_off", {31'b0, op_ready}, 0);
        end

        k = 0;
        while (!res_valid && k < 50) begin
            @(posedge clk);
            #1 k++;
        end
        chk("res_seen", {31'b0, res_valid}, 1);
        if (!res_valid) begin
            do_reset();
            return;
        end
        tv = cyc;
        exp_lat = (len == 0) ? t0 + 1 : h + 2 + MAC_LAT;
        chk("res_latency", tv - t0, exp_lat - t0);
        got = res_data;
        chk("res_data", res_data, exp_res);
        chk("en_pulses", en_cnt, exp_en);
        chk("clr_pulses", clr_cnt, (len > 0) ? 1 : 0);

        for (int j = 0; j < hold; j++) begin
            chk("hold_valid", {31'b0, res_valid}, 1);
            chk("hold_data", res_data, got);
            chk("hold_cmd_rdy", {30'b0, cmd_ready, busy}, 1);
            @(posedge clk);
            #1;
        end
        res_ready = 1'b1;
        @(posedge clk);
        #1 res_ready = 1'b0;
        chk("back_idle", {29'b0, res_valid, cmd_ready, busy}, 3'b010);
    endtask

    initial begin
        logic [15:0] got;
        int seen;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_mac", {mac_a, mac_b}, 0);
        chk("rst_ctl", {28'b0, mac_clr, mac_en, res_valid, busy}, 0);
        chk("rst_res", res_data, 0);
        rst = 1'b0;
        @(posedge clk);
        #1 chk("rst_cmd_rdy", {31'b0, cmd_ready}, 1);

        for (int j = 0; j < 4; j++) begin
            opa[j] = 16'h3E00;
            opb[j] = 16'h3E00;
        end
        run_cmd(4, 0, 0, 0, got);
        chk("len4_val", got, 16'h4200);

        run_cmd(0, 0, 0, 1, got);
        chk("len0_val", got, 16'h0000);

        run_cmd(3, 1, 0, 0, got);
        chk("alt3_val", got, 16'h4100);

        run_cmd(2, 0, 0, 10, got);

        // Reset mid-FEED after two of four pairs.
        cmd_valid = 1'b1;
        cmd_len = 8'd4;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        op_valid = 1'b1;
        op_a = 16'h4000;
        op_b = 16'h4000;
        repeat (3) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("mid_rst_ctl", {27'b0, mac_clr, mac_en, res_valid, busy, op_ready}, 0);
        chk("mid_rst_mac", {mac_a, mac_b}, 0);
        chk("mid_rst_res", res_data, 0);
        op_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        seen = 0;
        for (int j = 0; j < 6; j++) begin
            if (res_valid || busy) seen++;
            @(posedge clk);
            #1;
        end
        chk("no_partial", seen, 0);
        opa[0] = 16'h4000;
        opb[0] = 16'h3E00;
        run_cmd(1, 0, 0, 0, got);
        chk("post_rst_val", got, 16'h4000);

`ifdef DLMAC_NAN_ABORT_EN
        for (int j = 0; j < 3; j++) begin
            opa[j] = 16'h3E00;
            opb[j] = 16'h3E00;
        end
        opa[1] = 16'hFFFF;
        run_cmd(3, 0, 0, 0, got);
        chk("nan_val", got, 16'hFFFF);
        opa[1] = 16'h3E00;
        run_cmd(3, 0, 0, 0, got);
        chk("nan_cleared", got, 16'h4100);
`endif

        for (int t = 0; t < 25; t++) begin
            int len;
            len = $urandom_range(0, 12);
            for (int j = 0; j < len; j++) begin
                opa[j] = int2dl($urandom_range(1, 4));
                opb[j] = int2dl($urandom_range(1, 4));
            end
            run_cmd(len, 2, $urandom_range(0, 60), $urandom_range(0, 3), got);
        end

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
